pipelined_adder: RTL

Parametrised, pipelined successor to the combinational `adder` in `0_common`. It adds or subtracts two `WIDTH`-bit operands over `STAGES` clock cycles using a chunked carry chain, supports carry-in (ADC/SBC), and produces ARM-style NZCV flags. It sits between the register-read and writeback stages of the datapath and uses a valid/ready handshake so downstream stalls back-pressure the issuing logic.

---
 rtl/pipelined_adder.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with carry-in and NZCV flags.
// One CW-bit chunk of the carry chain is resolved per stage; valid/ready back-pressure freezes the whole pipe.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] add_out,
  output logic [3:0]       flags_out
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned CW1  = CW + 1;
  localparam int unsigned LAST = STAGES - 1;

  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_z   [STAGES];
  logic             r_vld [STAGES];
  logic [3:0]       r_flags;

  logic             w_stall;
  logic [WIDTH-1:0] w_a     [STAGES];
  logic [WIDTH-1:0] w_b     [STAGES];
  logic [WIDTH-1:0] w_s     [STAGES];
  logic [WIDTH-1:0] w_nxt_s [STAGES];
  logic             w_c     [STAGES];
  logic             w_z     [STAGES];
  logic             w_vld   [STAGES];
  logic [CW:0]      w_sum   [STAGES];
  logic             w_z_fin;
  logic             w_v_fin;
  logic [3:0]       w_flags;

  // Stage k consumes the registers of stage k-1; stage 0 consumes the prepared operands.
  always_comb begin
    w_stall  = r_vld[LAST] && !out_ready;
    in_ready = rst_n && !w_stall;

    w_a[0]   = a_in;
    w_b[0]   = op_in[0] ? ~b_in : b_in;
    w_s[0]   = '0;
    w_c[0]   = op_in[1] ? c_in : op_in[0];
    w_z[0]   = 1'b1;
    w_vld[0] = in_valid && in_ready;
    for (int k = 1; k < int'(STAGES); k++) begin
      w_a[k]   = r_a[k-1];
      w_b[k]   = r_b[k-1];
      w_s[k]   = r_s[k-1];
      w_c[k]   = r_c[k-1];
      w_z[k]   = r_z[k-1];
      w_vld[k] = r_vld[k-1];
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      w_sum[k]   = {1'b0, w_a[k][k*CW +: CW]} + {1'b0, w_b[k][k*CW +: CW]} + CW1'(w_c[k]);
      w_nxt_s[k] = w_s[k];
      w_nxt_s[k][k*CW +: CW] = w_sum[k][CW-1:0];
    end

    w_z_fin = w_z[LAST] && (w_sum[LAST][CW-1:0] == '0);
    w_v_fin = (w_a[LAST][WIDTH-1] == w_b[LAST][WIDTH-1]) &&
              (w_nxt_s[LAST][WIDTH-1] != w_a[LAST][WIDTH-1]);
    w_flags = {w_nxt_s[LAST][WIDTH-1], w_z_fin, w_sum[LAST][CW], w_v_fin};
  end

  // Data registers load only with a valid op, so outputs hold their last result across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_z[k]   <= 1'b0;
        r_vld[k] <= 1'b0;
      end
      r_flags <= 4'b0000;
    end else if (!w_stall) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_vld[k] <= w_vld[k];
        if (w_vld[k]) begin
          r_a[k] <= w_a[k];
          r_b[k] <= w_b[k];
          r_s[k] <= w_nxt_s[k];
          r_c[k] <= w_sum[k][CW];
          r_z[k] <= w_z[k] && (w_sum[k][CW-1:0] == '0);
        end
      end
      if (w_vld[LAST]) begin
        r_flags <= w_flags;
      end
    end
  end

  assign out_valid = r_vld[LAST];
  assign add_out   = r_s[LAST];
  assign flags_out = r_flags;

endmodule
